// File: rtl/execute_load_store_ctrl.sv
// execute_load_store_ctrl: one-at-a-time load/store sequencer to the data bus; MIST32E10FA_LOAD_STORE_TIMEOUT_EN adds a response timeout
module execute_load_store_ctrl #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iEXE_REQ,
  output logic        oEXE_BUSY,
  input  logic        iEXE_FLUSH,
  input  logic        iEXE_RW,
  input  logic [1:0]  iEXE_SIZE,
  input  logic [31:0] iEXE_ADDR,
  input  logic [31:0] iEXE_DATA,
  output logic        oDATAIO_REQ,
  input  logic        iDATAIO_BUSY,
  output logic        oDATAIO_RW,
  output logic [31:0] oDATAIO_ADDR,
  output logic [3:0]  oDATAIO_MASK,
  output logic [31:0] oDATAIO_DATA,
  input  logic        iDATAIO_VALID,
  input  logic [31:0] iDATAIO_DATA,
  output logic        oLOAD_VALID,
  output logic        oLOAD_SHIFT_EN,
  output logic [3:0]  oLOAD_MASK,
  output logic [1:0]  oLOAD_SHIFT,
  output logic [31:0] oLOAD_DATA,
  output logic        oSTORE_DONE,
  output logic        oFAULT_VALID,
  output logic [1:0]  oFAULT_CODE
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;
  state_t state, next;
  logic idle_req, misaligned, accept, timeout, load_pulse, store_pulse, fault_pulse;
  logic shift_en;
  logic [1:0] shift, fault_code;
  logic [3:0] mask;
  logic [31:0] wdata;
  assign idle_req = state == IDLE & iEXE_REQ & !iEXE_FLUSH;
  assign misaligned = (iEXE_SIZE == 2'd1 & iEXE_ADDR[0]) | (iEXE_SIZE[1] & |iEXE_ADDR[1:0]);
  assign accept = idle_req & !misaligned;
  always_comb begin
    mask = iEXE_SIZE[1] ? 4'hf : iEXE_SIZE[0] ? (iEXE_ADDR[1] ? 4'b1100 : 4'b0011) : 4'b0001 << iEXE_ADDR[1:0];
    wdata = iEXE_SIZE[1] ? iEXE_DATA : iEXE_SIZE[0] ? {2{iEXE_DATA[15:0]}} : {4{iEXE_DATA[7:0]}};
  end
`ifdef MIST32E10FA_LOAD_STORE_TIMEOUT_EN
  logic [15:0] cnt;
  assign timeout = state[1] & cnt == 16'(TIMEOUT_CYCLES);
  always_ff @(posedge iCLOCK)
    if (iRESET_SYNC | next != state) cnt <= '0;
    else if (state[1] & !iDATAIO_VALID) cnt <= cnt + 16'd1;
`else
  assign timeout = 1'b0;
`endif
  always_comb
    next = state == IDLE ? (accept ? ISSUE : IDLE)
         : state == ISSUE ? (iEXE_FLUSH ? IDLE : iDATAIO_BUSY ? ISSUE : WAIT)
         : (iDATAIO_VALID | timeout) ? IDLE
         : (state == WAIT & iEXE_FLUSH) ? DRAIN : state;
  always_comb begin
    load_pulse = state == WAIT & iDATAIO_VALID & !oDATAIO_RW;
    store_pulse = state == WAIT & iDATAIO_VALID & oDATAIO_RW;
    fault_pulse = (idle_req & misaligned) | (state == WAIT & !iDATAIO_VALID & timeout);
    fault_code = (idle_req & misaligned) ? 2'b01 : fault_pulse ? 2'b10 : 2'b00;
  end
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state <= IDLE;
      oEXE_BUSY <= 1'b0;
      oDATAIO_REQ <= 1'b0;
      oDATAIO_RW <= 1'b0;
      oDATAIO_ADDR <= '0;
      oDATAIO_MASK <= '0;
      oDATAIO_DATA <= '0;
      shift <= '0;
      shift_en <= 1'b0;
      oLOAD_VALID <= 1'b0;
      oLOAD_SHIFT_EN <= 1'b0;
      oLOAD_MASK <= '0;
      oLOAD_SHIFT <= '0;
      oLOAD_DATA <= '0;
      oSTORE_DONE <= 1'b0;
      oFAULT_VALID <= 1'b0;
      oFAULT_CODE <= '0;
    end else begin
      state <= next;
      oEXE_BUSY <= next != IDLE;
      oDATAIO_REQ <= next == ISSUE;
      oLOAD_VALID <= load_pulse;
      oSTORE_DONE <= store_pulse;
      oFAULT_VALID <= fault_pulse;
      oFAULT_CODE <= fault_code;
      if (accept) begin
        oDATAIO_RW <= iEXE_RW;
        oDATAIO_ADDR <= {iEXE_ADDR[31:2], 2'b00};
        oDATAIO_MASK <= mask;
        oDATAIO_DATA <= wdata;
        shift <= iEXE_ADDR[1:0];
        shift_en <= !iEXE_SIZE[1];
      end
      if (load_pulse) begin
        oLOAD_SHIFT_EN <= shift_en;
        oLOAD_MASK <= oDATAIO_MASK;
        oLOAD_SHIFT <= shift;
        oLOAD_DATA <= iDATAIO_DATA;
      end
    end
  end
endmodule
